// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: hazard controller state encodings and the
// default mul/div timeout.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MD_BUSY    = 2'd1,
        ST_REDIR_WAIT = 2'd2
    } hz_state_t;

    localparam int unsigned MD_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Purely combinational; x0 as a destination never creates a hazard.
module hazard_detect #(
    parameter int unsigned XLEN_REG = 5
) (
    input  logic [XLEN_REG-1:0] id_rs1,
    input  logic [XLEN_REG-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                ex_memread,
    input  logic [XLEN_REG-1:0] ex_rd,
    output logic                load_use
);

    always_comb begin
        load_use = ex_memread && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, redirect flushes, fetch
// stalls and multi-cycle mul/div freeze with timeout. PIPE_HAZARD_CTRL_PERF_EN adds counters.
module pipe_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int unsigned XLEN_REG   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [XLEN_REG-1:0] id_rs1,
    input  logic [XLEN_REG-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                ex_memread,
    input  logic [XLEN_REG-1:0] ex_rd,
    input  logic                ex_redirect,
    input  logic                ex_md_start,
    input  logic                md_done,
    input  logic                imem_ready,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                if_id_flush,
    output logic                id_ex_en,
    output logic                id_ex_flush,
    output logic                ex_mem_flush,
    output logic                md_timeout,
    output logic [1:0]          state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);

    hz_state_t  state, state_nxt;
    logic [7:0] md_cnt;
    logic       load_use;
    logic       md_expire;
    logic       pc_en_c, if_id_en_c, if_id_flush_c;
    logic       id_ex_en_c, id_ex_flush_c, ex_mem_flush_c, md_timeout_c;

    hazard_detect #(.XLEN_REG(XLEN_REG)) u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    assign md_expire = (state == ST_MD_BUSY) && !md_done &&
                       (md_cnt == 8'(MD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (state == ST_RUN && state_nxt == ST_MD_BUSY) begin
            md_cnt <= '0;
        end else if (state == ST_MD_BUSY) begin
            md_cnt <= md_cnt + 8'd1;
        end
    end

    // RUN priority: redirect > mul/div start > load-use > fetch stall
    always_comb begin
        state_nxt      = state;
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_en_c     = 1'b1;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        md_timeout_c   = 1'b0;
        case (state)
            ST_RUN: begin
                if (ex_redirect) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (!imem_ready) state_nxt = ST_REDIR_WAIT;
                end else if (ex_md_start) begin
                    state_nxt = ST_MD_BUSY;
                end else if (load_use) begin
                    pc_en_c       = 1'b0;
                    if_id_en_c    = 1'b0;
                    id_ex_flush_c = 1'b1;
                end else if (!imem_ready) begin
                    pc_en_c       = 1'b0;
                    if_id_flush_c = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                pc_en_c        = 1'b0;
                if_id_en_c     = 1'b0;
                id_ex_en_c     = 1'b0;
                ex_mem_flush_c = 1'b1;
                if (md_done) begin
                    state_nxt = ST_RUN;
                end else if (md_expire) begin
                    md_timeout_c = 1'b1;
                    state_nxt    = ST_RUN;
                end
            end
            ST_REDIR_WAIT: begin
                pc_en_c       = imem_ready;
                if_id_flush_c = !imem_ready;
                id_ex_flush_c = !imem_ready;
                if (imem_ready) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Reset overrides outputs combinationally so the pipe is held asynchronously
    assign pc_en        = reset_n & pc_en_c;
    assign if_id_en     = reset_n & if_id_en_c;
    assign id_ex_en     = reset_n & id_ex_en_c;
    assign if_id_flush  = !reset_n | if_id_flush_c;
    assign id_ex_flush  = !reset_n | id_ex_flush_c;
    assign ex_mem_flush = !reset_n | ex_mem_flush_c;
    assign md_timeout   = reset_n & md_timeout_c;
    assign state_o      = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance and an
// MD_TIMEOUT=4 instance share stimulus; expectations go through a scoreboard queue.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_redirect, ex_md_start, md_done, imem_ready;

    logic       m_pc_en, m_if_id_en, m_if_id_flush, m_id_ex_en, m_id_ex_flush, m_ex_mem_flush, m_md_timeout;
    logic [1:0] m_state;
    logic       t_pc_en, t_if_id_en, t_if_id_flush, t_id_ex_en, t_id_ex_flush, t_ex_mem_flush, t_md_timeout;
    logic [1:0] t_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] m_stall_cnt, m_flush_cnt, t_stall_cnt, t_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .ex_md_start(ex_md_start), .md_done(md_done), .imem_ready(imem_ready),
        .pc_en(m_pc_en), .if_id_en(m_if_id_en), .if_id_flush(m_if_id_flush),
        .id_ex_en(m_id_ex_en), .id_ex_flush(m_id_ex_flush), .ex_mem_flush(m_ex_mem_flush),
        .md_timeout(m_md_timeout), .state_o(m_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cnt(m_stall_cnt), .flush_cnt(m_flush_cnt)
`endif
    );

    pipe_hazard_ctrl #(.MD_TIMEOUT(4)) dut_t4 (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .ex_md_start(ex_md_start), .md_done(md_done), .imem_ready(imem_ready),
        .pc_en(t_pc_en), .if_id_en(t_if_id_en), .if_id_flush(t_if_id_flush),
        .id_ex_en(t_id_ex_en), .id_ex_flush(t_id_ex_flush), .ex_mem_flush(t_ex_mem_flush),
        .md_timeout(t_md_timeout), .state_o(t_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt)
`endif
    );

    // Packed view: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, md_timeout, state}
    logic [8:0] obs_m, obs_t;
    assign obs_m = {m_pc_en, m_if_id_en, m_if_id_flush, m_id_ex_en, m_id_ex_flush, m_ex_mem_flush, m_md_timeout, m_state};
    assign obs_t = {t_pc_en, t_if_id_en, t_if_id_flush, t_id_ex_en, t_id_ex_flush, t_ex_mem_flush, t_md_timeout, t_state};

    localparam logic [8:0] RUN_OK  = {7'b1101000, 2'd0};
    localparam logic [8:0] RST     = {7'b0010110, 2'd0};
    localparam logic [8:0] LDUSE   = {7'b0001100, 2'd0};
    localparam logic [8:0] REDIR   = {7'b1111100, 2'd0};
    localparam logic [8:0] FBUB    = {7'b0111000, 2'd0};
    localparam logic [8:0] MD      = {7'b0000010, 2'd1};
    localparam logic [8:0] MD_TO   = {7'b0000011, 2'd1};
    localparam logic [8:0] RW_WAIT = {7'b0111100, 2'd2};
    localparam logic [8:0] RW_GO   = {7'b1101000, 2'd2};

    typedef struct {
        string      tag;
        logic [8:0] exp;
        bit         t4;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        ex_redirect = 1'b0; ex_md_start = 1'b0; md_done = 1'b0; imem_ready = 1'b1;
    endtask

    // Inputs are already driven (posedge+1); queue expectations, compare at negedge.
    task automatic step(input string tag, input logic [8:0] e_m, input logic [8:0] e_t);
        sb_t it;
        logic [8:0] got;
        sb_q.push_back('{tag, e_m, 1'b0});
        sb_q.push_back('{tag, e_t, 1'b1});
        @(negedge clk);
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            got = it.t4 ? obs_t : obs_m;
            total++;
            assert (got === it.exp) else begin
                bad++;
                $error("FAIL %s%s observed=%b expected=%b", it.tag, it.t4 ? "/t4" : "", got, it.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf_zero(input string tag);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        total++;
        assert ({m_stall_cnt, m_flush_cnt, t_stall_cnt, t_flush_cnt} === 128'd0) else begin
            bad++;
            $error("FAIL %s observed=%h/%h/%h/%h expected=0", tag, m_stall_cnt, m_flush_cnt, t_stall_cnt, t_flush_cnt);
        end
`else
        if (tag.len() == 0) $display("perf counters not built");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        step("reset0", RST, RST);
        step("reset1", RST, RST);
        check_perf_zero("perf_reset");
        reset_n = 1'b1;
        step("run_idle", RUN_OK, RUN_OK);

        // Load-use on rs1, then the bubble clears the hazard
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step("lu_rs1", LDUSE, LDUSE);
        ex_memread = 1'b0;
        step("lu_bubble_once", RUN_OK, RUN_OK);
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_use_rs1 = 1'b0;
        step("lu_rs2", LDUSE, LDUSE);
        id_use_rs2 = 1'b0; id_rs1 = 5'd7;
        step("lu_unused_src", RUN_OK, RUN_OK);
        ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step("lu_x0", RUN_OK, RUN_OK);

        // Redirect overrides load-use
        ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1;
        step("redir_lu", REDIR, REDIR);
        idle_inputs();
        step("redir_after", RUN_OK, RUN_OK);

        imem_ready = 1'b0;
        step("fetch_bubble", FBUB, FBUB);

        // Redirect with fetch not ready: three cycles in REDIR_WAIT
        ex_redirect = 1'b1;
        step("rw_enter", REDIR, REDIR);
        ex_redirect = 1'b0;
        step("rw_wait1", RW_WAIT, RW_WAIT);
        step("rw_wait2", RW_WAIT, RW_WAIT);
        imem_ready = 1'b1;
        step("rw_go", RW_GO, RW_GO);
        step("rw_run", RUN_OK, RUN_OK);

        // Mul/div, md_done in 10th busy cycle; t4 instance times out in 4th
        ex_md_start = 1'b1;
        step("md_start", RUN_OK, RUN_OK);
        ex_md_start = 1'b0;
        for (int i = 1; i <= 3; i++) step("md_busy", MD, MD);
        step("md_busy4", MD, MD_TO);
        for (int i = 5; i <= 9; i++) step("md_busy_t4run", MD, RUN_OK);
        md_done = 1'b1;
        step("md_done10", MD, RUN_OK);
        md_done = 1'b0;
        step("md_exit", RUN_OK, RUN_OK);

        // md_done coinciding with the timeout wins without a pulse
        ex_md_start = 1'b1;
        step("md2_start", RUN_OK, RUN_OK);
        ex_md_start = 1'b0;
        for (int i = 1; i <= 3; i++) step("md2_busy", MD, MD);
        md_done = 1'b1;
        step("md2_done_at_to", MD, MD);
        md_done = 1'b0;
        step("md2_exit", RUN_OK, RUN_OK);

        // md_start beats load-use; redirect beats md_start
        ex_md_start = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step("md_vs_lu", RUN_OK, RUN_OK);
        idle_inputs(); md_done = 1'b1;
        step("md_vs_lu_busy", MD, MD);
        md_done = 1'b0;
        step("md_vs_lu_exit", RUN_OK, RUN_OK);
        ex_md_start = 1'b1; ex_redirect = 1'b1;
        step("redir_vs_md", REDIR, REDIR);
        idle_inputs();
        step("redir_vs_md_run", RUN_OK, RUN_OK);

        // Reset aborts MD_BUSY
        ex_md_start = 1'b1;
        step("md3_start", RUN_OK, RUN_OK);
        ex_md_start = 1'b0;
        step("md3_busy", MD, MD);
        reset_n = 1'b0;
        step("md3_reset", RST, RST);
        check_perf_zero("perf_md_reset");
        reset_n = 1'b1;
        step("md3_release", RUN_OK, RUN_OK);

        // Reset aborts REDIR_WAIT; released with fetch stalled shows plain RUN bubble
        ex_redirect = 1'b1; imem_ready = 1'b0;
        step("rw2_enter", REDIR, REDIR);
        ex_redirect = 1'b0;
        step("rw2_wait", RW_WAIT, RW_WAIT);
        reset_n = 1'b0;
        step("rw2_reset", RST, RST);
        reset_n = 1'b1;
        step("rw2_release", FBUB, FBUB);
        imem_ready = 1'b1;
        step("rw2_run", RUN_OK, RUN_OK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_TIMEOUT, default 64, giving the maximum MD_BUSY cycles before forced exit (legal range 2..255).
REQ-002 The block SHALL have parameter XLEN_REG, default 5, giving the register-index width.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_redirect  in  1  EX branch/jump taken (PC mispredict).
- ex_md_start  in  1  EX instruction is a multi-cycle mul/div.
- md_done  in  1  mul/div unit result valid (1-cycle pulse).
- imem_ready  in  1  fetch data valid this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID synchronous clear (drives its reset input).
- id_ex_en, id_ex_flush  out  1  ID/EX enable / clear.
- ex_mem_flush  out  1  EX/MEM clear (bubble).
- md_timeout  out  1  1-cycle error pulse.
- state_o  out  2  current FSM state, for debug.

Function
REQ-004 The block SHALL implement FSM states RUN=0, MD_BUSY=1, REDIR_WAIT=2; state 3 is illegal and SHALL map to RUN on the next edge.
REQ-005 In RUN with no hazard, the block SHALL drive pc_en=if_id_en=id_ex_en=1 and all flushes=0.
REQ-006 A load-use hazard is ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); in RUN it SHALL give pc_en=0, if_id_en=0 and id_ex_flush=1 in the same cycle, with combinational detection and exactly one bubble per hazard.
REQ-007 ex_redirect in RUN SHALL give pc_en=1, if_id_flush=1 and id_ex_flush=1 in the same cycle, and SHALL override a simultaneous load-use hazard.
REQ-008 If ex_redirect and !imem_ready occur together, the FSM SHALL enter REDIR_WAIT.
- In REDIR_WAIT: if_id_flush=1 and id_ex_flush=1 until imem_ready=1, then RUN.
REQ-009 !imem_ready in RUN without redirect SHALL give pc_en=0 and if_id_flush=1 (fetch bubble); ID/EX proceeds.
REQ-010 ex_md_start in RUN SHALL move the FSM to MD_BUSY on the next edge (ex_md_start beats load-use and imem stall; ex_redirect beats ex_md_start).
- MD_BUSY outputs: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1.
- Exit to RUN: on the edge after md_done=1.
REQ-011 An 8-bit counter SHALL clear on MD_BUSY entry and increment each MD_BUSY cycle.
- When it reaches MD_TIMEOUT-1 without md_done: md_timeout pulses for 1 cycle and the FSM returns to RUN.
- md_done in the same cycle as the timeout SHALL win, with no pulse.
REQ-012 md_done outside MD_BUSY SHALL be ignored.

Reset
REQ-013 While reset_n=0, the block SHALL force state=RUN and counter=0.
- Outputs during reset: pc_en=if_id_en=id_ex_en=0, if_id_flush=id_ex_flush=ex_mem_flush=1, md_timeout=0.
REQ-014 Reset asserted mid-MD_BUSY or mid-REDIR_WAIT SHALL abort the state immediately; the first cycle after release is RUN.

Configuration
REQ-015 With PIPE_HAZARD_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0], both saturating and reset to 0.
- stall_cnt increments on each cycle with pc_en=0 outside reset.
- flush_cnt increments on each cycle with if_id_flush=1 outside reset.
REQ-016 Without PIPE_HAZARD_CTRL_PERF_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-017 State encodings and the default MD_TIMEOUT SHALL live in the shared package riscv_pkg.
REQ-018 Hazard detection SHALL be a combinational sub-module hazard_detect (load-use compare only); the FSM, counter and output muxing stay in pipe_hazard_ctrl.

Verification
REQ-019 Load-use:
- Stimulus: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1.
- Response: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; ex_rd=0 gives no stall.
REQ-020 Redirect plus load-use in the same cycle:
- Response: pc_en=1, if_id_flush=1, id_ex_flush=1, no stall.
REQ-021 Redirect with imem_ready=0 for 3 cycles:
- Response: state_o=2 for 3 cycles, flushes held, then RUN on the cycle imem_ready=1.
REQ-022 Mul/div with md_done at cycle 10:
- Response: MD_BUSY for 10 cycles with ex_mem_flush=1; md_timeout never set.
REQ-023 Timeout with MD_TIMEOUT=4 and no md_done:
- Response: md_timeout pulses in the 4th MD_BUSY cycle, then RUN.
- Variant: md_done in the same cycle gives no pulse.
REQ-024 reset_n low during MD_BUSY:
- Response: outputs take reset values asynchronously; RUN after release.
- With PIPE_HAZARD_CTRL_PERF_EN defined: counters read 0.
